// File: rtl/riscv_insn_prefetch.sv
// Instruction prefetch buffer: issues sequential fetches, queues in-order responses for decode.
// Define RISCV_PREFETCH_PERF_EN to add the stall_count decode-starvation counter.
module riscv_insn_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [XLEN-1:0] insn_data,
  output logic [XLEN-1:0] insn_pc
`ifdef RISCV_PREFETCH_PERF_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   outst_q, outst_d;
  logic [PW-1:0]   discard_q, discard_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]   pcq_wptr_q, pcq_wptr_d, pcq_rptr_q, pcq_rptr_d;
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [XLEN-1:0] pcq_q       [DEPTH];

  logic [PW-1:0]   occ;
  logic [PW:0]     inflight;
  logic            empty, full;
  logic            req_hs, resp_ok, push, pop;

  assign occ      = wptr_q - rptr_q;
  assign inflight = {1'b0, occ} + {1'b0, outst_q};
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
  assign mem_req_valid = !reset && !redirect_valid && (discard_q == '0) &&
                         (inflight < (PW+1)'(DEPTH));
  assign mem_req_addr  = pc_q;
  assign insn_valid    = !reset && !empty;
  assign insn_data     = insn_valid ? fifo_data_q[rptr_q[AW-1:0]] : '0;
  assign insn_pc       = insn_valid ? fifo_pc_q[rptr_q[AW-1:0]] : '0;

  assign req_hs  = mem_req_valid && mem_req_ready;
  assign resp_ok = mem_resp_valid && (outst_q != '0);
  assign pop     = insn_valid && insn_ready && !redirect_valid;
  assign push    = resp_ok && (discard_q == '0) && !redirect_valid && (!full || pop);

  always_comb begin
    pc_d       = pc_q;
    discard_d  = discard_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    pcq_wptr_d = pcq_wptr_q;
    pcq_rptr_d = pcq_rptr_q;
    outst_d    = outst_q + PW'(req_hs) - PW'(resp_ok);
    if (req_hs) begin
      pc_d       = pc_q + XLEN'(4);
      pcq_wptr_d = pcq_wptr_q + PW'(1);
    end
    // Every accepted response retires its PC-queue entry, whether kept or dropped.
    if (resp_ok) pcq_rptr_d = pcq_rptr_q + PW'(1);
    if (resp_ok && (discard_q != '0)) discard_d = discard_q - PW'(1);
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop) rptr_d = rptr_q + PW'(1);
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      rptr_d    = wptr_q;
      discard_d = outst_q - PW'(resp_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      pcq_wptr_q <= '0;
      pcq_rptr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      pcq_wptr_q <= pcq_wptr_d;
      pcq_rptr_q <= pcq_rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wptr_q[AW-1:0]] <= mem_resp_data;
      fifo_pc_q[wptr_q[AW-1:0]]   <= pcq_q[pcq_rptr_q[AW-1:0]];
    end
    if (req_hs) pcq_q[pcq_wptr_q[AW-1:0]] <= pc_q;
  end

`ifdef RISCV_PREFETCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (insn_ready && !insn_valid && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_riscv_insn_prefetch.sv
// Bench for riscv_insn_prefetch: latency-configurable memory model with a fetch scoreboard.
// Build with RISCV_PREFETCH_PERF_EN defined to exercise stall_count as well.
module tb_riscv_insn_prefetch;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset = 1'b1;
  logic            mem_req_valid, mem_req_ready = 1'b1;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid = 1'b0;
  logic [XLEN-1:0] mem_resp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            insn_valid, insn_ready = 1'b0;
  logic [XLEN-1:0] insn_data, insn_pc;

  logic            w_req_valid, w_insn_valid;
  logic [XLEN-1:0] w_req_addr, w_insn_data, w_insn_pc;
  logic            w_one = 1'b1, w_zero = 1'b0;
  logic [XLEN-1:0] w_zero_w = '0;
`ifdef RISCV_PREFETCH_PERF_EN
  logic [31:0] stall_count, w_stall_count;
`endif

  riscv_insn_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data), .insn_pc(insn_pc)
`ifdef RISCV_PREFETCH_PERF_EN
    , .stall_count(stall_count)
`endif
  );

  riscv_insn_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clock(clock), .reset(reset),
    .mem_req_valid(w_req_valid), .mem_req_ready(w_one), .mem_req_addr(w_req_addr),
    .mem_resp_valid(w_zero), .mem_resp_data(w_zero_w),
    .redirect_valid(w_zero), .redirect_pc(w_zero_w),
    .insn_valid(w_insn_valid), .insn_ready(w_zero), .insn_data(w_insn_data), .insn_pc(w_insn_pc)
`ifdef RISCV_PREFETCH_PERF_EN
    , .stall_count(w_stall_count)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } sb_t;
  typedef struct { int lat; logic rdy; int ncyc; int exp_req; int exp_pop; } vec_t;

  pend_t       pend[$];
  sb_t         sb[$];
  int          checks = 0, passes = 0;
  int          cyc = 0, lat = 1;
  int          n_req = 0, n_pop = 0, w_n = 0;
  logic [31:0] exp_addr = 32'h0, w_exp_addr = 32'hFFFF_FFF8;
  logic        redir_arm = 1'b0, got_pop = 1'b0;
  int          stale_seen, stale3_cyc, first_req_cyc;
  logic [31:0] first_req_addr, first_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One clock: observe handshakes mid-cycle, then let the memory model answer after the edge.
  task automatic tick();
    pend_t p;
    sb_t   e;
    @(negedge clock);
    if (reset) begin
      check("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_insn_valid", insn_valid, 1'b0);
      pend.delete();
      sb.delete();
      exp_addr   = 32'h0;
      w_exp_addr = 32'hFFFF_FFF8;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, exp_addr);
        pend.push_back('{mem_req_addr, cyc + lat});
        sb.push_back('{exp_addr, mem_word(exp_addr)});
        exp_addr += 32'd4;
        n_req++;
        if (redir_arm && first_req_cyc < 0) begin
          first_req_cyc  = cyc;
          first_req_addr = mem_req_addr;
        end
      end
      if (redir_arm && mem_resp_valid) begin
        stale_seen++;
        if (stale_seen == 3) stale3_cyc = cyc;
      end
      if (redirect_valid) check("redirect_blocks_req", mem_req_valid, 1'b0);
      if (insn_valid && insn_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL insn_unexpected: got pc 0x%08h, expected no valid instruction", insn_pc);
        end else begin
          e = sb.pop_front();
          check("insn_pc", insn_pc, e.pc);
          check("insn_data", insn_data, e.data);
        end
        n_pop++;
        if (redir_arm && !got_pop) begin
          got_pop      = 1'b1;
          first_pop_pc = insn_pc;
        end
      end
      if (redirect_valid) begin
        sb.delete();
        exp_addr = redirect_pc;
      end
      if (w_req_valid) begin
        check("wrap_req_addr", w_req_addr, w_exp_addr);
        w_exp_addr += 32'd4;
        w_n++;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(p.addr);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    insn_ready     = 1'b0;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_addr", mem_req_addr, 32'h0);
    check("post_rst_insn_pc", insn_pc, 32'h0);
    check("post_rst_insn_data", insn_data, 32'h0);
    check("post_rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
  endtask

  vec_t vt[4];
  int   r0, p0;

  initial begin
    vt[0] = '{1, 1'b1, 20, 20, 18};
    vt[1] = '{1, 1'b0, 20, DEPTH, 0};
    vt[2] = '{2, 1'b1, 20, 20, 17};
    vt[3] = '{2, 1'b0, 20, DEPTH, 0};

    for (int i = 0; i < 4; i++) begin
      lat = vt[i].lat;
      do_reset();
      insn_ready = vt[i].rdy;
      r0 = n_req;
      p0 = n_pop;
      repeat (vt[i].ncyc) tick();
      check($sformatf("vec%0d_reqs", i), n_req - r0, vt[i].exp_req);
      check($sformatf("vec%0d_pops", i), n_pop - p0, vt[i].exp_pop);
    end

    // Full buffer: requests stay off until decode takes one word.
    lat = 1;
    do_reset();
    repeat (20) tick();
    check("full_req_valid", mem_req_valid, 1'b0);
    insn_ready = 1'b1;
    tick();
    insn_ready = 1'b0;
    #1;
    check("after_pop_req_valid", mem_req_valid, 1'b1);
    check("after_pop_addr", mem_req_addr, 32'h10);

    // Redirect with three fetches in flight.
    lat = 10;
    do_reset();
    insn_ready = 1'b1;
    repeat (3) tick();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    redir_arm      = 1'b1;
    got_pop        = 1'b0;
    stale_seen     = 0;
    stale3_cyc     = -1;
    first_req_cyc  = -1;
    tick();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    for (int k = 0; k < 60 && !got_pop; k++) tick();
    redir_arm = 1'b0;
    if (!got_pop) begin
      checks++;
      $display("FAIL redirect_timeout: got no instruction after redirect, expected pc 0x100");
    end else begin
      check("redir_first_addr", first_req_addr, 32'h100);
      check("redir_first_req_cycle", first_req_cyc, stale3_cyc + 1);
      check("redir_first_insn_pc", first_pop_pc, 32'h100);
    end

    // Redirect coinciding with a response and a pop.
    lat = 2;
    do_reset();
    insn_ready = 1'b1;
    repeat (6) tick();
    #1;
    check("r38_pre_insn_valid", insn_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("r38_n1_insn_valid", insn_valid, 1'b0);
    check("r38_n1_req_valid", mem_req_valid, 1'b0);
    tick();
    #1;
    check("r38_n2_insn_valid", insn_valid, 1'b0);
    check("r38_n2_req_valid", mem_req_valid, 1'b1);
    check("r38_n2_addr", mem_req_addr, 32'h200);
    repeat (10) tick();

    // Response with nothing outstanding is ignored.
    lat = 1;
    do_reset();
    mem_req_ready  = 1'b0;
    insn_ready     = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_BAD0;
    tick();
    #1;
    check("spurious_insn_valid", insn_valid, 1'b0);
    check("spurious_req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    p0 = n_pop;
    repeat (10) tick();
    check("spurious_recovery_pops", n_pop - p0, 8);

`ifdef RISCV_PREFETCH_PERF_EN
    lat = 5;
    do_reset();
    check("stall_rst", stall_count, 32'd0);
    insn_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (insn_valid) break;
      tick();
    end
    if (!insn_valid) begin
      checks++;
      $display("FAIL stall_timeout: got no insn_valid, expected one after 6 cycles");
    end else begin
      check("stall_at_first_valid", stall_count, 32'd6);
    end
`endif

    check("wrap_issued_enough", (w_n >= 3), 1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1);
  end

endmodule
